// File: rtl/lab2_mem_responder_pkg.sv
// Shared memory-message types for the lab2 memory responder: type/len codes,
// request/response structs, FSM state type and a byte-length mask helper.
package lab2_mem_responder_pkg;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
    localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;

    // len 0 means a full 4-byte access; 1..3 count bytes.
    localparam logic [1:0] MEM_LEN_4B = 2'd0;
    localparam logic [1:0] MEM_LEN_1B = 2'd1;
    localparam logic [1:0] MEM_LEN_2B = 2'd2;
    localparam logic [1:0] MEM_LEN_3B = 2'd3;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    function automatic logic [31:0] len_mask(input logic [1:0] len);
        case (len)
            MEM_LEN_1B: len_mask = 32'h0000_00FF;
            MEM_LEN_2B: len_mask = 32'h0000_FFFF;
            MEM_LEN_3B: len_mask = 32'h00FF_FFFF;
            default:    len_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/lab2_mem_resp_queue.sv
// Two-entry response FIFO with val/rdy on both sides; head stays put while stalled.
module lab2_mem_resp_queue
    import lab2_mem_responder_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  mem_resp_4B_t enq_msg,
    input  logic         enq_val,
    output logic         enq_rdy,
    output mem_resp_4B_t deq_msg,
    output logic         deq_val,
    input  logic         deq_rdy
);

    mem_resp_4B_t entries [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_enq;
    logic         do_deq;

    assign enq_rdy = (count != 2'd2);
    assign deq_val = (count != 2'd0);
    assign deq_msg = entries[rd_ptr];
    assign do_enq  = enq_val && enq_rdy;
    assign do_deq  = deq_val && deq_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entries[0] <= '0;
            entries[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
        end else begin
            if (do_enq) begin
                entries[wr_ptr] <= enq_msg;
                wr_ptr          <= ~wr_ptr;
            end
            if (do_deq) begin
                rd_ptr <= ~rd_ptr;
            end
            if (do_enq && !do_deq) begin
                count <= count + 2'd1;
            end else if (do_deq && !do_enq) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/lab2_mem_responder.sv
// Word-addressed memory responder with optional fixed extra latency and a 2-entry
// response FIFO. Define LAB2_MEM_RESPONDER_SUBWORD_EN for byte-granular len/addr[1:0].
module lab2_mem_responder
    import lab2_mem_responder_pkg::*;
#(
    parameter int p_num_words = 256,
    parameter int p_latency   = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  mem_req_4B_t  reqstream_msg,
    input  logic         reqstream_val,
    output logic         reqstream_rdy,
    output mem_resp_4B_t respstream_msg,
    output logic         respstream_val,
    input  logic         respstream_rdy
);

    localparam int AW = $clog2(p_num_words);

    logic [31:0]   mem [p_num_words];
    state_t        state;
    logic [2:0]    count;
    logic          rdy_en;
    mem_resp_4B_t  pend_msg;
    mem_resp_4B_t  resp_now;
    mem_resp_4B_t  enq_msg;
    logic          enq_val;
    logic          q_enq_rdy;
    logic          accept;
    logic          is_read;
    logic          is_write;
    logic [AW-1:0] word_idx;
    logic [31:0]   old_word;
    logic [31:0]   wr_word;
    logic [31:0]   rd_data;
    logic [1:0]    resp_len;
    logic          unused_bits;

    assign word_idx = reqstream_msg.addr[AW+1:2];
    assign old_word = mem[word_idx];
    assign is_read  = (reqstream_msg.msg_type == MEM_TYPE_READ);
    assign is_write = (reqstream_msg.msg_type == MEM_TYPE_WRITE) ||
                      (reqstream_msg.msg_type == MEM_TYPE_INIT);

    // rdy_en keeps ready low through reset and for the edge that releases it.
    assign reqstream_rdy = rdy_en && (state == IDLE) && q_enq_rdy;
    assign accept        = reqstream_val && reqstream_rdy;
    assign unused_bits   = ^{reqstream_msg.addr[31:AW+2], reqstream_msg.addr[1:0],
                             reqstream_msg.len};

`ifdef LAB2_MEM_RESPONDER_SUBWORD_EN
    logic [4:0]  shamt;
    logic [31:0] wmask;
    assign shamt = {reqstream_msg.addr[1:0], 3'b000};
    assign wmask = len_mask(reqstream_msg.len) << shamt;

    always_comb begin
        wr_word  = (old_word & ~wmask) | ((reqstream_msg.data << shamt) & wmask);
        rd_data  = (old_word >> shamt) & len_mask(reqstream_msg.len);
        resp_len = reqstream_msg.len;
    end
`else
    always_comb begin
        wr_word  = reqstream_msg.data;
        rd_data  = old_word;
        resp_len = MEM_LEN_4B;
    end
`endif

    always_comb begin
        resp_now          = '0;
        resp_now.msg_type = reqstream_msg.msg_type;
        resp_now.opaque   = reqstream_msg.opaque;
        resp_now.test     = 2'd0;
        resp_now.len      = resp_len;
        resp_now.data     = is_read ? rd_data : 32'd0;
    end

    // Memory is deliberately not reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (accept && is_write) begin
            mem[word_idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= 3'd0;
            rdy_en   <= 1'b0;
            pend_msg <= '0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept && (p_latency != 0)) begin
                        state    <= WAIT;
                        count    <= 3'(p_latency);
                        pend_msg <= resp_now;
                    end
                end
                WAIT: begin
                    count <= count - 3'd1;
                    if (count == 3'd1) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Room is guaranteed at enqueue: accept required a non-full queue and
    // nothing else enqueues while in WAIT.
    assign enq_val = (p_latency == 0) ? accept : ((state == WAIT) && (count == 3'd1));
    assign enq_msg = (p_latency == 0) ? resp_now : pend_msg;

    lab2_mem_resp_queue u_queue (
        .clk     (clk),
        .reset   (reset),
        .enq_msg (enq_msg),
        .enq_val (enq_val),
        .enq_rdy (q_enq_rdy),
        .deq_msg (respstream_msg),
        .deq_val (respstream_val),
        .deq_rdy (respstream_rdy)
    );

endmodule

// File: tb/tb_lab2_mem_responder.sv
// Self-checking bench: a zero-latency and a three-cycle-latency responder, vector
// table plus hand sequences for backpressure, latency, wrap, subword and reset.
module tb_lab2_mem_responder;
    import lab2_mem_responder_pkg::*;

    localparam int W = $bits(mem_resp_4B_t);
`ifdef LAB2_MEM_RESPONDER_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    typedef struct {
        mem_req_4B_t  req;
        mem_resp_4B_t resp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_req_4B_t  req0_msg, req3_msg;
    logic         req0_val, req0_rdy, req3_val, req3_rdy;
    mem_resp_4B_t resp0_msg, resp3_msg;
    logic         resp0_val, resp0_rdy, resp3_val, resp3_rdy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp3_q[$];
    int resp0_cyc[$];
    vec_t vecs[$];

    lab2_mem_responder #(.p_num_words(256), .p_latency(0)) dut0 (
        .clk(clk), .reset(reset),
        .reqstream_msg(req0_msg), .reqstream_val(req0_val), .reqstream_rdy(req0_rdy),
        .respstream_msg(resp0_msg), .respstream_val(resp0_val), .respstream_rdy(resp0_rdy)
    );

    lab2_mem_responder #(.p_num_words(256), .p_latency(3)) dut3 (
        .clk(clk), .reset(reset),
        .reqstream_msg(req3_msg), .reqstream_val(req3_val), .reqstream_rdy(req3_rdy),
        .respstream_msg(resp3_msg), .respstream_val(resp3_val), .respstream_rdy(resp3_rdy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic mem_req_4B_t mk_req(input logic [2:0] t, input logic [7:0] op,
                                           input logic [31:0] a, input logic [1:0] l,
                                           input logic [31:0] d);
        mem_req_4B_t m;
        m.msg_type = t; m.opaque = op; m.addr = a; m.len = l; m.data = d;
        return m;
    endfunction

    function automatic mem_resp_4B_t mk_resp(input logic [2:0] t, input logic [7:0] op,
                                             input logic [1:0] l, input logic [31:0] d);
        mem_resp_4B_t m;
        m.msg_type = t; m.opaque = op; m.test = 2'd0; m.len = SUBWORD ? l : 2'd0; m.data = d;
        return m;
    endfunction

    always @(negedge clk) begin
        if (reset && resp0_val && resp0_rdy) begin
            if (exp0_q.size() == 0) check("resp0_unexpected", 64'd1, 64'd0);
            else check("resp0_msg", 64'(resp0_msg), 64'(exp0_q.pop_front()));
            resp0_cyc.push_back(cyc);
        end
        if (reset && resp3_val && resp3_rdy) begin
            if (exp3_q.size() == 0) check("resp3_unexpected", 64'd1, 64'd0);
            else check("resp3_msg", 64'(resp3_msg), 64'(exp3_q.pop_front()));
        end
    end

    task automatic send0(input mem_req_4B_t m, input mem_resp_4B_t e);
        bit ok = 1'b0;
        req0_msg = m;
        req0_val = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_rdy) begin ok = 1'b1; break; end
        end
        if (!ok) check("send0_timeout", 64'd0, 64'd1);
        else exp0_q.push_back(e);
        @(posedge clk); #1;
        req0_val = 1'b0;
    endtask

    task automatic send3(input mem_req_4B_t m, input mem_resp_4B_t e);
        bit ok = 1'b0;
        req3_msg = m;
        req3_val = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req3_rdy) begin ok = 1'b1; break; end
        end
        if (!ok) check("send3_timeout", 64'd0, 64'd1);
        else exp3_q.push_back(e);
        @(posedge clk); #1;
        req3_val = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (exp0_q.size() == 0 && exp3_q.size() == 0) break;
        end
        @(posedge clk); #1;
        check(name, 64'(exp0_q.size() + exp3_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int acc;
        int seen;
        bit ok;
        req0_msg = '0; req0_val = 1'b0; resp0_rdy = 1'b1;
        req3_msg = '0; req3_val = 1'b0; resp3_rdy = 1'b1;

        // reset state and first-edge ready
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy0", 64'(req0_rdy), 64'd0);
        check("rst_val0", 64'(resp0_val), 64'd0);
        check("rst_rdy3", 64'(req3_rdy), 64'd0);
        check("rst_val3", 64'(resp3_val), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rdy_before_first_edge", 64'(req0_rdy), 64'd0);
        @(posedge clk); #1;
        check("rdy0_after_first_edge", 64'(req0_rdy), 64'd1);
        check("rdy3_after_first_edge", 64'(req3_rdy), 64'd1);

        // vector table, issued back-to-back on the zero-latency instance
        vecs.push_back('{mk_req(MEM_TYPE_WRITE, 8'h01, 32'h1000, 2'd0, 32'hDEADBEEF),
                         mk_resp(MEM_TYPE_WRITE, 8'h01, 2'd0, 32'h0)});
        vecs.push_back('{mk_req(MEM_TYPE_READ, 8'h02, 32'h1000, 2'd0, 32'h0),
                         mk_resp(MEM_TYPE_READ, 8'h02, 2'd0, 32'hDEADBEEF)});
        vecs.push_back('{mk_req(MEM_TYPE_WRITE, 8'h03, 32'h400, 2'd0, 32'h55),
                         mk_resp(MEM_TYPE_WRITE, 8'h03, 2'd0, 32'h0)});
        vecs.push_back('{mk_req(MEM_TYPE_READ, 8'h04, 32'h0, 2'd0, 32'h0),
                         mk_resp(MEM_TYPE_READ, 8'h04, 2'd0, 32'h55)});
        vecs.push_back('{mk_req(MEM_TYPE_INIT, 8'h05, 32'h8, 2'd0, 32'h12345678),
                         mk_resp(MEM_TYPE_INIT, 8'h05, 2'd0, 32'h0)});
        vecs.push_back('{mk_req(MEM_TYPE_READ, 8'h06, 32'h8, 2'd0, 32'h0),
                         mk_resp(MEM_TYPE_READ, 8'h06, 2'd0, 32'h12345678)});
        vecs.push_back('{mk_req(3'd3, 8'h07, 32'h8, 2'd0, 32'hFFFFFFFF),
                         mk_resp(3'd3, 8'h07, 2'd0, 32'h0)});
        vecs.push_back('{mk_req(MEM_TYPE_READ, 8'h08, 32'h8, 2'd0, 32'h0),
                         mk_resp(MEM_TYPE_READ, 8'h08, 2'd0, 32'h12345678)});
        vecs.push_back('{mk_req(MEM_TYPE_WRITE, 8'h09, 32'h3FC, 2'd0, 32'hCAFEF00D),
                         mk_resp(MEM_TYPE_WRITE, 8'h09, 2'd0, 32'h0)});
        vecs.push_back('{mk_req(MEM_TYPE_READ, 8'h0A, 32'hFFC, 2'd0, 32'h0),
                         mk_resp(MEM_TYPE_READ, 8'h0A, 2'd0, 32'hCAFEF00D)});
        vecs.push_back('{mk_req(MEM_TYPE_READ, 8'h0B, 32'h9, 2'd2, 32'h0),
                         mk_resp(MEM_TYPE_READ, 8'h0B, 2'd2,
                                 SUBWORD ? 32'h00003456 : 32'h12345678)});
        for (int i = 0; i < vecs.size(); i++) send0(vecs[i].req, vecs[i].resp);
        drain("table_drain");
        check("wr_rd_consecutive", 64'(resp0_cyc[1] - resp0_cyc[0]), 64'd1);

        // subword access, or proof that len/addr[1:0] are ignored
        send0(mk_req(MEM_TYPE_WRITE, 8'h50, 32'h20, 2'd0, 32'h11223344),
              mk_resp(MEM_TYPE_WRITE, 8'h50, 2'd0, 32'h0));
        send0(mk_req(MEM_TYPE_WRITE, 8'h51, 32'h21, 2'd1, 32'hAA),
              mk_resp(MEM_TYPE_WRITE, 8'h51, 2'd1, 32'h0));
        send0(mk_req(MEM_TYPE_READ, 8'h52, 32'h20, 2'd0, 32'h0),
              mk_resp(MEM_TYPE_READ, 8'h52, 2'd0, SUBWORD ? 32'h1122AA44 : 32'h000000AA));
        send0(mk_req(MEM_TYPE_READ, 8'h53, 32'h22, 2'd2, 32'h0),
              mk_resp(MEM_TYPE_READ, 8'h53, 2'd2, SUBWORD ? 32'h00001122 : 32'h000000AA));
        drain("subword_drain");

        // backpressure: two accepted, queue full, head held stable
        resp0_rdy = 1'b0;
        send0(mk_req(MEM_TYPE_READ, 8'h40, 32'h8, 2'd0, 32'h0),
              mk_resp(MEM_TYPE_READ, 8'h40, 2'd0, 32'h12345678));
        send0(mk_req(MEM_TYPE_READ, 8'h41, 32'h8, 2'd0, 32'h0),
              mk_resp(MEM_TYPE_READ, 8'h41, 2'd0, 32'h12345678));
        req0_msg = mk_req(MEM_TYPE_READ, 8'h42, 32'h8, 2'd0, 32'h0);
        req0_val = 1'b1;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (req0_rdy) acc++;
            check("bp_head_stable", 64'(resp0_msg), 64'(exp0_q[0]));
        end
        check("bp_no_accept", 64'(acc), 64'd0);
        check("bp_queued", 64'(exp0_q.size()), 64'd2);
        @(posedge clk); #1;
        resp0_rdy = 1'b1;
        @(negedge clk);
        check("full_deq_same_cycle_rdy", 64'(req0_rdy), 64'd0);
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (req0_rdy) begin ok = 1'b1; break; end
        end
        if (ok) exp0_q.push_back(mk_resp(MEM_TYPE_READ, 8'h42, 2'd0, 32'h12345678));
        else check("bp_resume_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req0_val = 1'b0;
        send0(mk_req(MEM_TYPE_READ, 8'h43, 32'h8, 2'd0, 32'h0),
              mk_resp(MEM_TYPE_READ, 8'h43, 2'd0, 32'h12345678));
        drain("bp_drain");

        // latency 3: response exactly 4 cycles after accept, rdy low meanwhile
        send3(mk_req(MEM_TYPE_WRITE, 8'h20, 32'h10, 2'd0, 32'hA5A5A5A5),
              mk_resp(MEM_TYPE_WRITE, 8'h20, 2'd0, 32'h0));
        drain("lat_write_drain");
        send3(mk_req(MEM_TYPE_READ, 8'h21, 32'h10, 2'd0, 32'h0),
              mk_resp(MEM_TYPE_READ, 8'h21, 2'd0, 32'hA5A5A5A5));
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("lat_rdy_low", 64'(req3_rdy), 64'd0);
            check("lat_val_low", 64'(resp3_val), 64'd0);
        end
        @(negedge clk);
        check("lat_val_high", 64'(resp3_val), 64'd1);
        drain("lat_read_drain");

        // reset during WAIT discards the in-flight request
        send3(mk_req(MEM_TYPE_READ, 8'h30, 32'h10, 2'd0, 32'h0),
              mk_resp(MEM_TYPE_READ, 8'h30, 2'd0, 32'hA5A5A5A5));
        reset = 1'b0;
        exp3_q.delete();
        #1;
        check("rst_wait_rdy", 64'(req3_rdy), 64'd0);
        check("rst_wait_val", 64'(resp3_val), 64'd0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp3_val) seen++;
        end
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (resp3_val) seen++;
        end
        check("rst_wait_no_resp", 64'(seen), 64'd0);
        @(posedge clk); #1;
        send3(mk_req(MEM_TYPE_READ, 8'h31, 32'h10, 2'd0, 32'h0),
              mk_resp(MEM_TYPE_READ, 8'h31, 2'd0, 32'hA5A5A5A5));
        drain("post_reset_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
